// File: rtl/ir_sample_if.sv
// Links the IR sweep sequencer to the A2D converter and to the error-compute consumer.
// The master side is the sequencer, and the slave side is the A2D plus the consumer.
`timescale 1ns/100ps
interface ir_sample_if #(
    parameter int DATA_W = 12
);
    logic              IR_en;
    logic              strt_cnv;
    logic [2:0]        chnnl;
    logic              cnv_cmplt;
    logic [DATA_W-1:0] res;
    logic [2:0]        sel;
    logic [DATA_W-1:0] ir_data;
    logic              IR_vld;
    logic              a2d_tmo;

    modport master (
        output IR_en, strt_cnv, chnnl, ir_data, IR_vld, a2d_tmo,
        input  cnv_cmplt, res, sel
    );

    modport slave (
        input  IR_en, strt_cnv, chnnl, ir_data, IR_vld, a2d_tmo,
        output cnv_cmplt, res, sel
    );
endinterface

// File: rtl/ir_sample_sm.sv
// Periodic IR sweep sequencer. It powers the emitters, converts 8 channels through the A2D,
// and publishes each complete sweep from a shadow bank, signalled with a 1-cycle IR_vld.
`timescale 1ns/100ps
module ir_sample_sm #(
    parameter int NUM_CH     = 8,
    parameter int DATA_W     = 12,
    parameter int PERIOD_CYC = 100000,
    parameter int SETTLE_CYC = 2048,
    parameter int TMO_CYC    = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    ir_sample_if.master  ir
);

    localparam int PER_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);

    typedef enum logic [2:0] {IDLE, SETTLE, START, WAIT, DONE} state_t;

    state_t            state;
    logic [PER_W-1:0]  timer;
    logic [SET_W-1:0]  settle_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [2:0]        ch;
    logic [DATA_W-1:0] shadow [NUM_CH];
    logic [DATA_W-1:0] pub    [NUM_CH];
    logic              tick;

    assign tick       = en && (timer == PER_W'(PERIOD_CYC - 1));
    assign ir.ir_data = pub[ir.sel];

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            timer <= '0;
        end else if (tick) begin
            timer <= '0;
        end else begin
            timer <= timer + PER_W'(1);
        end
    end

    // The published bank is written only when a sweep completes, so the consumer
    // sees one coherent sweep across its whole accumulation window.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ir.IR_en    <= 1'b0;
            ir.strt_cnv <= 1'b0;
            ir.chnnl    <= 3'd0;
            ir.IR_vld   <= 1'b0;
            ir.a2d_tmo  <= 1'b0;
            settle_cnt  <= '0;
            tmo_cnt     <= '0;
            ch          <= 3'd0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow[i] <= '0;
                pub[i]    <= '0;
            end
        end else begin
            ir.strt_cnv <= 1'b0;
            ir.IR_vld   <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        state      <= SETTLE;
                        settle_cnt <= '0;
                        ir.IR_en   <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SET_W'(SETTLE_CYC - 1)) begin
                        state       <= START;
                        ch          <= 3'd0;
                        ir.chnnl    <= 3'd0;
                        ir.strt_cnv <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end
                end
                START: begin
                    state   <= WAIT;
                    tmo_cnt <= '0;
                end
                WAIT: begin
                    if (ir.cnv_cmplt) begin
                        shadow[ch] <= ir.res;
                        if (ch == LAST_CH) begin
                            state      <= DONE;
                            ir.IR_vld  <= 1'b1;
                            ir.a2d_tmo <= 1'b0;
                            ir.IR_en   <= 1'b0;
                            for (int i = 0; i < NUM_CH; i++) begin
                                pub[i] <= (i == NUM_CH - 1) ? ir.res : shadow[i];
                            end
                        end else begin
                            state       <= START;
                            ch          <= ch + 3'd1;
                            ir.chnnl    <= ch + 3'd1;
                            ir.strt_cnv <= 1'b1;
                        end
                    end else if (tmo_cnt == TMO_W'(TMO_CYC - 1)) begin
                        // Abandon the sweep. The last good publication stays visible.
                        state      <= IDLE;
                        ir.a2d_tmo <= 1'b1;
                        ir.IR_en   <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ir_sample_sm.sv
// Randomized bench for ir_sample_sm. A behavioural A2D model records the value it returns
// on each channel, and the expected published bank is the set of values from the last complete sweep.
`timescale 1ns/100ps
module tb_ir_sample_sm;
    localparam int DATA_W = 12;
    localparam int PERIOD = 64;
    localparam int SETTLE = 4;
    localparam int TMO    = 16;

    logic clk = 1'b0;
    logic rst;
    logic en;
    always #5 clk = ~clk;

    ir_sample_if #(.DATA_W(DATA_W)) ifc ();

    ir_sample_sm #(
        .NUM_CH(8), .DATA_W(DATA_W), .PERIOD_CYC(PERIOD),
        .SETTLE_CYC(SETTLE), .TMO_CYC(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .ir(ifc.master)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int rst_cyc = 0;
    int withhold_ch = -1;
    int spur_cnt = 0;
    int spur_seen = 0;
    bit res_base_en = 1'b1;
    logic [DATA_W-1:0] res_base = '0;
    logic [DATA_W-1:0] gen     [8];
    logic [DATA_W-1:0] exp_pub [8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic check_all_sel(input string tag);
        logic [2:0] s0;
        s0 = ifc.sel;
        for (int k = 0; k < 8; k++) begin
            ifc.sel = 3'(k);
            #0.5;
            chk(tag, 32'(ifc.ir_data), 32'(exp_pub[k]));
        end
        ifc.sel = s0;
        #0.5;
    endtask

    // A2D model: it answers 2 cycles after each strt_cnv, except on a withheld channel,
    // and it can inject one spurious strobe on request.
    initial begin
        int pend_cnt;
        int pend_ch;
        pend_cnt = 0;
        pend_ch = 0;
        for (int k = 0; k < 8; k++) gen[k] = '0;
        ifc.cnv_cmplt = 1'b0;
        ifc.res = '0;
        forever begin
            @(posedge clk);
            #1;
            ifc.cnv_cmplt = 1'b0;
            if (spur_cnt != spur_seen) begin
                spur_seen = spur_cnt;
                ifc.cnv_cmplt = 1'b1;
                ifc.res = 12'hFFF;
            end
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    ifc.cnv_cmplt = 1'b1;
                    ifc.res = gen[pend_ch];
                end
            end
            if (ifc.strt_cnv === 1'b1) begin
                pend_ch = int'(ifc.chnnl);
                if (res_base_en) gen[pend_ch] = res_base + DATA_W'(pend_ch);
                else gen[pend_ch] = DATA_W'($urandom_range(0, 12'hFFE));
                pend_cnt = (pend_ch == withhold_ch) ? 0 : 2;
            end
        end
    end

    // Follows one sweep from the idle gap to its end. The sweep ends on publication,
    // on a timeout, or on a reset injected at rst_ch.
    task automatic run_sweep(input int rst_ch, input int drop_ch, input bit spur,
                             output int n_vld, output int tmo_lat, output int ren_cyc);
        int n_strt;
        int w_cyc;
        bit prev_tmo;
        bit done;
        bit rst_armed;
        n_strt = 0;
        w_cyc = 0;
        done = 1'b0;
        rst_armed = 1'b0;
        n_vld = 0;
        tmo_lat = -1;
        ren_cyc = -1;
        prev_tmo = ifc.a2d_tmo;
        for (int k = 0; k < 400 && !done; k++) begin
            step();
            if (rst_armed) begin
                rst = 1'b1;
                step();
                chk("rst_ir_en", 32'(ifc.IR_en), 0);
                chk("rst_ir_vld", 32'(ifc.IR_vld), 0);
                chk("rst_strt_cnv", 32'(ifc.strt_cnv), 0);
                chk("rst_a2d_tmo", 32'(ifc.a2d_tmo), 0);
                rst = 1'b0;
                rst_cyc = cyc;
                for (int j = 0; j < 8; j++) exp_pub[j] = '0;
                check_all_sel("rst_ir_data");
                done = 1'b1;
            end else begin
                if (ifc.IR_en === 1'b1 && ren_cyc < 0) begin
                    ren_cyc = cyc;
                    if (spur) spur_cnt++;
                end
                if (ifc.strt_cnv === 1'b1) begin
                    if (n_strt == 0) chk("settle_lat", 32'(cyc - ren_cyc), SETTLE);
                    chk("chnnl_order", 32'(ifc.chnnl), 32'(n_strt));
                    if (n_strt == withhold_ch) w_cyc = cyc;
                    if (n_strt == drop_ch) en = 1'b0;
                    if (n_strt == rst_ch) rst_armed = 1'b1;
                    n_strt++;
                end
                if (ifc.IR_vld === 1'b1) begin
                    n_vld++;
                    chk("strt_count", 32'(n_strt), 8);
                    chk("tmo_cleared", 32'(ifc.a2d_tmo), 0);
                    for (int j = 0; j < 8; j++) exp_pub[j] = gen[j];
                end
                chk("ir_data_sel", 32'(ifc.ir_data), 32'(exp_pub[ifc.sel]));
                if (ifc.IR_vld === 1'b1) begin
                    check_all_sel("ir_data_pub");
                    step();
                    chk("vld_one_cycle", 32'(ifc.IR_vld), 0);
                    chk("ir_en_off", 32'(ifc.IR_en), 0);
                    done = 1'b1;
                end else if (ifc.a2d_tmo === 1'b1 && !prev_tmo) begin
                    tmo_lat = cyc - w_cyc;
                    chk("tmo_ir_en", 32'(ifc.IR_en), 0);
                    done = 1'b1;
                end
                prev_tmo = ifc.a2d_tmo;
            end
        end
        chk("sweep_done", 32'(done), 1);
    endtask

    initial begin
        int nv, tl, rn, prev_ren, rel, ns, ne;
        rst = 1'b1;
        en = 1'b0;
        ifc.sel = 3'd0;
        for (int k = 0; k < 8; k++) exp_pub[k] = '0;
        repeat (3) step();
        chk("reset_ir_en", 32'(ifc.IR_en), 0);
        chk("reset_strt_cnv", 32'(ifc.strt_cnv), 0);
        chk("reset_chnnl", 32'(ifc.chnnl), 0);
        chk("reset_ir_vld", 32'(ifc.IR_vld), 0);
        chk("reset_a2d_tmo", 32'(ifc.a2d_tmo), 0);
        check_all_sel("reset_ir_data");
        rst = 1'b0;
        en = 1'b1;
        rel = cyc;

        // Fixed-pattern sweeps: 0x100+ch, then 0x200+ch with sel held at 3.
        res_base_en = 1'b1;
        res_base = 12'h100;
        run_sweep(-1, -1, 1'b0, nv, tl, rn);
        chk("t1_vld", 32'(nv), 1);
        chk("t1_first_tick", 32'(rn - rel), PERIOD);
        prev_ren = rn;
        res_base = 12'h200;
        ifc.sel = 3'd3;
        run_sweep(-1, -1, 1'b0, nv, tl, rn);
        chk("t2_vld", 32'(nv), 1);
        chk("t2_period", 32'(rn - prev_ren), PERIOD);
        chk("t2_sel3", 32'(ifc.ir_data), 32'(exp_pub[3]));
        prev_ren = rn;

        // Timeout on channel 5; the sweep-2 data must survive.
        res_base_en = 1'b0;
        withhold_ch = 5;
        run_sweep(-1, -1, 1'b0, nv, tl, rn);
        chk("t3_no_vld", 32'(nv), 0);
        chk("t3_tmo_lat", 32'(tl), TMO + 1);
        chk("t3_tmo_flag", 32'(ifc.a2d_tmo), 1);
        withhold_ch = -1;
        check_all_sel("t3_keep");
        prev_ren = rn;

        // A spurious strobe during settle, followed by a good sweep that clears the timeout.
        run_sweep(-1, -1, 1'b1, nv, tl, rn);
        chk("t4_vld", 32'(nv), 1);
        chk("t4_tmo_clr", 32'(ifc.a2d_tmo), 0);
        chk("t4_period", 32'(rn - prev_ren), PERIOD);
        prev_ren = rn;

        for (int r = 0; r < 6; r++) begin
            int wh;
            bit sp;
            ifc.sel = 3'($urandom_range(0, 7));
            wh = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
            sp = 1'($urandom_range(0, 1));
            withhold_ch = wh;
            run_sweep(-1, -1, sp, nv, tl, rn);
            chk("rnd_vld", 32'(nv), (wh < 0) ? 1 : 0);
            if (wh >= 0) chk("rnd_tmo_lat", 32'(tl), TMO + 1);
            else chk("rnd_tmo_clr", 32'(ifc.a2d_tmo), 0);
            chk("rnd_period", 32'(rn - prev_ren), PERIOD);
            prev_ren = rn;
            withhold_ch = -1;
        end

        // Reset while waiting on channel 4; the timer restarts from zero.
        run_sweep(4, -1, 1'b0, nv, tl, rn);
        chk("t5_no_vld", 32'(nv), 0);
        run_sweep(-1, -1, 1'b0, nv, tl, rn);
        chk("t5_vld_after", 32'(nv), 1);
        chk("t5_timer_restart", 32'(rn - rst_cyc), PERIOD);

        // Drop en mid-sweep: the sweep still publishes, and then no sweeps start.
        run_sweep(-1, 2, 1'b0, nv, tl, rn);
        chk("t6_vld", 32'(nv), 1);
        ns = 0;
        ne = 0;
        for (int k = 0; k < 3 * PERIOD; k++) begin
            step();
            if (ifc.strt_cnv === 1'b1) ns++;
            if (ifc.IR_en === 1'b1) ne++;
        end
        chk("t6_no_strt", 32'(ns), 0);
        chk("t6_no_ir_en", 32'(ne), 0);
        en = 1'b1;
        rel = cyc;
        run_sweep(-1, -1, 1'b0, nv, tl, rn);
        chk("t6_resume_vld", 32'(nv), 1);
        chk("t6_resume_tick", 32'(rn - rel), PERIOD);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
